// File: rtl/sat_cnt_pkg.sv
// Shared types and the saturating-increment helper for the sat_cnt_sched counter bank.
package sat_cnt_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Width-agnostic up to 32 bits; callers pass their own all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or after ptr, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/sat_cnt_sched.sv
// Bank of saturating event counters sharing one increment path, served round-robin.
// Events latch as pending; one pending requester is granted and incremented per cycle.
module sat_cnt_sched
  import sat_cnt_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [NREQ-1:0]       req_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ*WIDTH-1:0] cnt_o,
  output logic [NREQ-1:0]       sat_o,
  output logic [NREQ-1:0]       ovf_o
);

  localparam int PW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] CNT_ONES = '1;

  logic [NREQ-1:0]  pend_q, pend_d;
  logic [NREQ-1:0]  ovf_q,  ovf_d;
  logic [PW-1:0]    ptr_q,  ptr_d;
  logic [WIDTH-1:0] cnt_q [NREQ];
  logic [WIDTH-1:0] cnt_d [NREQ];

  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx;
  logic             arb_en;

  // Clearing cycles never grant, so a clear cannot race an increment.
  assign arb_en = en_i & ~clr_i & ~rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (pend_q),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      pend_d = '0;
      ovf_d  = '0;
      for (int i = 0; i < NREQ; i++) cnt_d[i] = '0;
    end else begin
      if (|gnt) begin
        cnt_d[gnt_idx] = WIDTH'(sat_inc(32'(cnt_q[gnt_idx]), 32'(CNT_ONES)));
        ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      // A granted requester re-pulsing keeps its pending bit; others drop repeats.
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          pend_d[i] = req_i[i];
        end else if (req_i[i]) begin
          if (pend_q[i]) ovf_d[i] = 1'b1;
          else           pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign grant_o = gnt;
  assign ovf_o   = ovf_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_out
    assign cnt_o[g*WIDTH +: WIDTH] = cnt_q[g];
    assign sat_o[g]                = (cnt_q[g] == CNT_ONES);
  end

endmodule

// File: tb/tb_sat_cnt_sched.sv
// Randomised and directed bench for sat_cnt_sched against a behavioural counter-bank model.
module tb_sat_cnt_sched;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic             clk;
  logic             rst;
  logic             en_i;
  logic             clr_i;
  logic [N-1:0]     req_i;
  logic [N-1:0]     grant_o;
  logic [N*W-1:0]   cnt_o;
  logic [N-1:0]     sat_o;
  logic [N-1:0]     ovf_o;

  int total;
  int bad;

  // Behavioural model state.
  int   m_cnt  [N];
  bit   m_pend [N];
  bit   m_ovf  [N];
  int   m_ptr;

  logic [N-1:0] obs_gnt;
  logic [N-1:0] exp_gnt;

  sat_cnt_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .clr_i   (clr_i),
    .req_i   (req_i),
    .grant_o (grant_o),
    .cnt_o   (cnt_o),
    .sat_o   (sat_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_gnt(input logic en, input logic clr);
    if (!en || clr) return -1;
    for (int k = 0; k < N; k++) begin
      if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] exp_cnt_vec();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_sat_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] == MAX);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovf_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // One clock of stimulus; records observed and modelled grant, then advances the model.
  task automatic drive_cycle(input logic [N-1:0] req, input logic en, input logic clr);
    int g;
    logic [N-1:0] one;
    one   = 1;
    req_i = req;
    en_i  = en;
    clr_i = clr;
    @(negedge clk);
    obs_gnt = grant_o;
    g = model_gnt(en, clr);
    exp_gnt = (g >= 0) ? (one << g) : '0;
    @(posedge clk);
    #1;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      if (g >= 0) begin
        if (m_cnt[g] < MAX) m_cnt[g]++;
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (i == g)            m_pend[i] = req[i];
        else if (req[i]) begin
          if (m_pend[i]) m_ovf[i] = 1;
          else           m_pend[i] = 1;
        end
      end
    end
    req_i = '0;
    clr_i = 1'b0;
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    rst   = 1'b1;
    req_i = req;
    @(negedge clk);
    obs_gnt = grant_o;
    exp_gnt = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_i = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_cycle('0, 1'b1, 1'b0);
      total++;
      if (obs_gnt !== exp_gnt) begin
        bad++;
        $display("FAIL drain_grant got=%b want=%b", obs_gnt, exp_gnt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset('0);
    @(negedge clk);
    total++;
    if (grant_o !== '0 || cnt_o !== '0 || sat_o !== '0 || ovf_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b cnt=%h sat=%b ovf=%b want all zero",
               grant_o, cnt_o, sat_o, ovf_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    do_reset('0);
    drive_cycle(4'b0001, 1'b1, 1'b0);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL basic_no_early_grant got=%b want=0000", obs_gnt);
    end
    drive_cycle('0, 1'b1, 1'b0);
    total++;
    if (obs_gnt !== 4'b0001) begin
      bad++; $display("FAIL basic_grant got=%b want=0001", obs_gnt);
    end
    total++;
    if (cnt_o !== {8'd0, 8'd0, 8'd0, 8'd1}) begin
      bad++; $display("FAIL basic_cnt got=%h want=00000001", cnt_o);
    end
    total++;
    if (int'(dut.ptr_q) !== 1) begin
      bad++; $display("FAIL basic_ptr got=%0d want=1", dut.ptr_q);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] want [4];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset('0);
    drive_cycle(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive_cycle('0, 1'b1, 1'b0);
      total++;
      if (obs_gnt !== want[c]) begin
        bad++; $display("FAIL rotation_grant[%0d] got=%b want=%b", c, obs_gnt, want[c]);
      end
    end
    total++;
    if (cnt_o !== {8'd1, 8'd1, 8'd1, 8'd1} || ovf_o !== 4'b0000) begin
      bad++; $display("FAIL rotation_final got cnt=%h ovf=%b want cnt=01010101 ovf=0000", cnt_o, ovf_o);
    end
  endtask

  task automatic test_fairness();
    int c0, c2, diff;
    do_reset('0);
    for (int c = 0; c < 20; c++) begin
      drive_cycle(4'b0101, 1'b1, 1'b0);
      total++;
      if (obs_gnt !== exp_gnt) begin
        bad++; $display("FAIL fairness_grant[%0d] got=%b want=%b", c, obs_gnt, exp_gnt);
      end
    end
    drain(4);
    c0 = int'(cnt_o[0 +: W]);
    c2 = int'(cnt_o[2*W +: W]);
    diff = (c0 > c2) ? c0 - c2 : c2 - c0;
    total++;
    if (diff > 1 || c0 == 0) begin
      bad++; $display("FAIL fairness_balance got c0=%0d c2=%0d want nonzero within 1", c0, c2);
    end
    total++;
    if (ovf_o !== 4'b0101) begin
      bad++; $display("FAIL fairness_ovf got=%b want=0101", ovf_o);
    end
    total++;
    if (cnt_o !== exp_cnt_vec()) begin
      bad++; $display("FAIL fairness_cnt got=%h want=%h", cnt_o, exp_cnt_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset('0);
    for (int c = 0; c < 300; c++) begin
      drive_cycle(4'b0010, 1'b1, 1'b0);
      if (c == 200) begin
        total++;
        if (cnt_o[W +: W] !== 8'(c)) begin
          bad++; $display("FAIL sat_midway got=%0d want=%0d", cnt_o[W +: W], c);
        end
      end
    end
    drain(2);
    total++;
    if (cnt_o[W +: W] !== 8'd255 || sat_o !== 4'b0010) begin
      bad++; $display("FAIL sat_hold got cnt=%0d sat=%b want cnt=255 sat=0010", cnt_o[W +: W], sat_o);
    end
    total++;
    if (ovf_o !== 4'b0000 || cnt_o !== exp_cnt_vec()) begin
      bad++; $display("FAIL sat_others got cnt=%h ovf=%b want cnt=%h ovf=0000", cnt_o, ovf_o, exp_cnt_vec());
    end
  endtask

  task automatic test_enable_gating();
    do_reset('0);
    drive_cycle(4'b1000, 1'b0, 1'b0);
    drive_cycle(4'b0000, 1'b0, 1'b0);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL en_no_grant got=%b want=0000", obs_gnt);
    end
    drive_cycle(4'b1000, 1'b0, 1'b0);
    total++;
    if (ovf_o !== 4'b1000) begin
      bad++; $display("FAIL en_ovf got=%b want=1000", ovf_o);
    end
    drive_cycle('0, 1'b1, 1'b0);
    total++;
    if (obs_gnt !== 4'b1000) begin
      bad++; $display("FAIL en_grant got=%b want=1000", obs_gnt);
    end
    drain(3);
    total++;
    if (cnt_o !== {8'd1, 8'd0, 8'd0, 8'd0}) begin
      bad++; $display("FAIL en_cnt got=%h want=01000000", cnt_o);
    end
  endtask

  task automatic test_clear_and_reset();
    int ptr_before;
    do_reset('0);
    drive_cycle(4'b0111, 1'b1, 1'b0);
    drive_cycle(4'b0011, 1'b1, 1'b0);
    drive_cycle('0, 1'b1, 1'b0);
    ptr_before = m_ptr;
    drive_cycle(4'b1111, 1'b1, 1'b1);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL clr_no_grant got=%b want=0000", obs_gnt);
    end
    total++;
    if (cnt_o !== '0 || ovf_o !== '0 || sat_o !== '0) begin
      bad++; $display("FAIL clr_state got cnt=%h ovf=%b sat=%b want zeros", cnt_o, ovf_o, sat_o);
    end
    total++;
    if (int'(dut.ptr_q) !== ptr_before || ptr_before == 0) begin
      bad++; $display("FAIL clr_ptr got=%0d want=%0d (nonzero)", dut.ptr_q, ptr_before);
    end
    drive_cycle('0, 1'b1, 1'b0);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL clr_pend_cleared got=%b want=0000", obs_gnt);
    end
    drive_cycle(4'b1111, 1'b1, 1'b0);
    drive_cycle(4'b1111, 1'b1, 1'b0);
    do_reset(4'b1111);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL rst_no_grant got=%b want=0000", obs_gnt);
    end
    total++;
    if (cnt_o !== '0 || ovf_o !== '0 || int'(dut.ptr_q) !== 0) begin
      bad++; $display("FAIL rst_state got cnt=%h ovf=%b ptr=%0d want zeros", cnt_o, ovf_o, dut.ptr_q);
    end
    drive_cycle('0, 1'b1, 1'b0);
    total++;
    if (obs_gnt !== 4'b0000) begin
      bad++; $display("FAIL rst_pend_cleared got=%b want=0000", obs_gnt);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic en, clr;
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 99) < 2);
      drive_cycle(req, en, clr);
      total++;
      if (obs_gnt !== exp_gnt) begin
        bad++; $display("FAIL rand_grant[%0d] got=%b want=%b", c, obs_gnt, exp_gnt);
      end
      total++;
      if (cnt_o !== exp_cnt_vec() || ovf_o !== exp_ovf_vec() || sat_o !== exp_sat_vec()) begin
        bad++; $display("FAIL rand_state[%0d] got cnt=%h ovf=%b sat=%b want cnt=%h ovf=%b sat=%b",
                        c, cnt_o, ovf_o, sat_o, exp_cnt_vec(), exp_ovf_vec(), exp_sat_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en_i  = 1'b1;
    clr_i = 1'b0;
    req_i = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_basic_latency();
    test_rotation();
    test_fairness();
    test_saturation();
    test_enable_gating();
    test_clear_and_reset();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_cnt_sched.md
# sat_cnt_sched

Round-robin scheduler that shares one saturating increment datapath among `NREQ` event requesters. It owns the bank of per-requester event counters that sit upstream of the per-bit transition monitors. Each requester raises a one-cycle increment event. The scheduler latches the event as pending, grants one pending requester per cycle in rotating priority, and performs a saturating `+1` on that requester's counter. Counters hold at all-ones, matching the existing `cnt != '1` guard.

## Interface
- `NREQ`, default 4: number of requesters/counters, 2..16.
- `WIDTH`, default 8: counter width in bits.
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `en_i`  input  1: when low, no grants are issued; pending events still latch.
- `clr_i`  input  1: synchronous clear of counters, pending flags and overflow flags. Does not reset the rotation pointer.
- `req_i`  input  NREQ: bit i high for one cycle = one increment event for counter i.
- `grant_o`  output  NREQ: one-hot (or zero) grant in the current cycle. Combinational from registered state.
- `cnt_o`  output  NREQ*WIDTH: counter values, counter i at bits `[i*WIDTH +: WIDTH]`.
- `sat_o`  output  NREQ: bit i high when counter i equals all-ones.
- `ovf_o`  output  NREQ: sticky; an event for i was dropped.

## Operation
- **State:** `pend_q[NREQ]`, `cnt_q[NREQ][WIDTH]`, `ovf_q[NREQ]`, rotation pointer `ptr_q` ($clog2(NREQ) bits).
- **Reset:** all state zero. `grant_o`, `cnt_o`, `sat_o` and `ovf_o` are all 0 after reset.
- **Arbitration:**
  - Among `pend_q` bits, grant the first set bit searching `ptr_q`, `ptr_q+1`, … modulo NREQ.
  - No grant when `en_i`=0, when `clr_i`=1, or when no bit is pending.
- **On grant to i:**
  - `cnt_q[i]` <= `cnt_q[i]+1` if `cnt_q[i]` != all-ones, else hold. No wrap.
  - `ptr_q` <= (i+1) mod NREQ.
  - `pend_q[i]` cleared unless `req_i[i]` is high in the same cycle, in which case it stays set.
- **Event latch:** `req_i[i]` with `pend_q[i]`=0 sets `pend_q[i]`.
- **Overflow:** `req_i[i]` with `pend_q[i]`=1 and no grant to i in the same cycle drops the event and sets `ovf_q[i]`. `ovf_q[i]` stays set until `clr_i` or `rst`.
- **Saturated counters:** a grant to a saturated counter still consumes the pending event and still advances the pointer. This is not an overflow.
- **Priority:** `rst` > `clr_i` > normal operation. `req_i` in the same cycle as `clr_i` is discarded.
- **Per-cycle update:** at most one counter changes per cycle. Width arithmetic is WIDTH-bit unsigned with no carry out.

## Timing
- `req_i` sampled at edge t → `pend_q` set after t → `grant_o` visible in cycle t+1 if the requester wins → `cnt_o` updated after edge t+2.
- Minimum latency from request to counter update: 2 edges.
- Worst case with all requesters pending and `en_i`=1: NREQ+1 edges.
- Sustained throughput: one increment per cycle.
- Sustained `req_i[i]` every cycle is served without overflow only while i wins every cycle, i.e. only when no other requester is pending.
- `sat_o` and `ovf_o` are registered-state decodes, valid the cycle after the causing edge.
- `clr_i` or `rst` asserted mid-stream:
  - counters are zero in the next cycle;
  - no grant is issued in the clearing cycle;
  - for `clr_i`, the pointer keeps its value.

## Structure
- Package `sat_cnt_pkg`: `cnt_t` typedef parameterised by width, the `CNT_MAX` constant, and a `sat_inc` function (saturating add).
- Sub-module `rr_arbiter`, parameterised by `NREQ`:
  - inputs `req`, `ptr`, `en`;
  - outputs one-hot `gnt` and encoded `gnt_idx`;
  - purely combinational.
- The top-level holds all registers.
- Expected size: about 200 lines of RTL total.

## Test plan
- **Basic latency:** after reset, pulse `req_i`=0001 once → `grant_o`=0001 one cycle later, `cnt_o[0]`=1 one cycle after that, `ptr_q`=1, other counters 0.
- **Rotation:** `req_i`=1111 held for one cycle → grants 0001, 0010, 0100, 1000 on consecutive cycles; each counter =1 and `ovf_o`=0.
- **Fairness:** `req_i`=0101 every cycle for 20 cycles → grants alternate 0001/0100. Counters 0 and 2 differ by at most 1. `ovf_o`=0101, because events are dropped while the other requester is served.
- **Saturation:** WIDTH=8, drive 300 events to requester 1 with no contention → `cnt_o[1]`=255, `sat_o[1]`=1, no wrap to 0.
- **Enable gating:** `en_i`=0 while pulsing `req_i[3]` twice → no grant, `ovf_o[3]`=1. Raise `en_i` → exactly one increment, `cnt_o[3]`=1.
- **Clear and reset:** `clr_i` with `req_i`=1111 in the same cycle → counters, pending and overflow flags all 0, no grant, pointer unchanged. Repeat with `rst` → pointer also 0.
